mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Memory front-end: loads the font image, then a ROM byte stream, then arbitrates
// the single-port memory between the CPU and a read-only debug port (round-robin).
module mem_arbiter #(
  parameter logic [11:0] ROM_BASE  = 12'h200,
  parameter logic [11:0] FONT_BASE = 12'h000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rom_valid,
  input  logic [7:0]  rom_data,
  input  logic        rom_last,
  output logic        rom_ready,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_gnt,
  output logic        cpu_rvalid,
  output logic [7:0]  cpu_rdata,
  input  logic        dbg_req,
  input  logic [11:0] dbg_addr,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [7:0]  dbg_rdata,
  output logic [11:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        system_ready,
  output logic        rom_overflow,
  output logic [11:0] load_count
);

  typedef enum logic [1:0] {FONT, ROM, RUN} state_e;

  localparam int unsigned ROM_CAP = 32'd4096 - 32'(ROM_BASE);

  localparam logic [7:0] FONT_ROM [80] = '{
    8'hF0, 8'h90, 8'h90, 8'h90, 8'hF0,  8'h20, 8'h60, 8'h20, 8'h20, 8'h70,
    8'hF0, 8'h10, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h10, 8'hF0, 8'h10, 8'hF0,
    8'h90, 8'h90, 8'hF0, 8'h10, 8'h10,  8'hF0, 8'h80, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h80, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h10, 8'h20, 8'h40, 8'h40,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'hF0,  8'hF0, 8'h90, 8'hF0, 8'h10, 8'hF0,
    8'hF0, 8'h90, 8'hF0, 8'h90, 8'h90,  8'hE0, 8'h90, 8'hE0, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'h80, 8'h80, 8'hF0,  8'hE0, 8'h90, 8'h90, 8'h90, 8'hE0,
    8'hF0, 8'h80, 8'hF0, 8'h80, 8'hF0,  8'hF0, 8'h80, 8'hF0, 8'h80, 8'h80
  };

  state_e      state_q, state_d;
  logic [6:0]  font_idx_q, font_idx_d;
  logic [12:0] load_cnt_q, load_cnt_d;
  logic        rom_overflow_q, rom_overflow_d;
  logic        prio_dbg_q, prio_dbg_d;
  logic        cpu_rvalid_q, cpu_rvalid_d;
  logic        dbg_rvalid_q, dbg_rvalid_d;

  logic        rom_accept;
  logic        has_room;
  logic        mem_we_c;

  assign rom_accept = (state_q == ROM) && rom_valid;
  // 13-bit count so a zero ROM_BASE (4096-byte capacity) still compares correctly
  assign has_room   = ({19'd0, load_cnt_q} < ROM_CAP);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= FONT;
      font_idx_q     <= 7'd0;
      load_cnt_q     <= 13'd0;
      rom_overflow_q <= 1'b0;
      prio_dbg_q     <= 1'b0;
      cpu_rvalid_q   <= 1'b0;
      dbg_rvalid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      font_idx_q     <= font_idx_d;
      load_cnt_q     <= load_cnt_d;
      rom_overflow_q <= rom_overflow_d;
      prio_dbg_q     <= prio_dbg_d;
      cpu_rvalid_q   <= cpu_rvalid_d;
      dbg_rvalid_q   <= dbg_rvalid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FONT:    if (font_idx_q == 7'd79) state_d = ROM;
      ROM:     if (rom_accept && rom_last) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = FONT;
    endcase
  end

  // Grants are combinational; the pointer remembers who won last so a tie goes to the other side
  always_comb begin
    cpu_gnt = (state_q == RUN) && cpu_req && (!dbg_req || !prio_dbg_q);
    dbg_gnt = (state_q == RUN) && dbg_req && !cpu_gnt;

    prio_dbg_d = prio_dbg_q;
    if (cpu_gnt)      prio_dbg_d = 1'b1;
    else if (dbg_gnt) prio_dbg_d = 1'b0;

    cpu_rvalid_d = cpu_gnt && !cpu_we;
    dbg_rvalid_d = dbg_gnt;

    font_idx_d = (state_q == FONT) ? font_idx_q + 7'd1 : font_idx_q;

    load_cnt_d     = load_cnt_q;
    rom_overflow_d = rom_overflow_q;
    if (rom_accept) begin
      if (has_room) load_cnt_d     = load_cnt_q + 13'd1;
      else          rom_overflow_d = 1'b1;
    end
  end

  always_comb begin
    mem_we_c  = 1'b0;
    mem_addr  = 12'h000;
    mem_wdata = 8'h00;
    case (state_q)
      FONT: begin
        mem_we_c  = 1'b1;
        mem_addr  = FONT_BASE + {5'd0, font_idx_q};
        mem_wdata = FONT_ROM[font_idx_q];
      end
      ROM: begin
        mem_we_c  = rom_accept && has_room;
        mem_addr  = ROM_BASE + load_cnt_q[11:0];
        mem_wdata = rom_data;
      end
      RUN: begin
        if (cpu_gnt) begin
          mem_we_c  = cpu_we;
          mem_addr  = cpu_addr;
          mem_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
          mem_addr  = dbg_addr;
        end
      end
      default: mem_we_c = 1'b0;
    endcase
  end

  // Gate with reset so no write is presented while the block is held in reset
  assign mem_we       = rst_in && mem_we_c;
  assign rom_ready    = (state_q == ROM);
  assign system_ready = (state_q == RUN);
  assign rom_overflow = rom_overflow_q;
  assign load_count   = load_cnt_q[12] ? 12'hFFF : load_cnt_q[11:0];
  assign cpu_rvalid   = cpu_rvalid_q;
  assign dbg_rvalid   = dbg_rvalid_q;
  assign cpu_rdata    = cpu_rvalid_q ? mem_rdata : 8'h00;
  assign dbg_rdata    = dbg_rvalid_q ? mem_rdata : 8'h00;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a phase-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam logic [11:0] ROM_BASE  = 12'h200;
  localparam logic [11:0] FONT_BASE = 12'h000;
  localparam int          CAP       = 4096 - 32'h200;

  localparam logic [39:0] GLYPH [16] = '{
    40'hF0909090F0, 40'h2060202070, 40'hF010F080F0, 40'hF010F010F0,
    40'h9090F01010, 40'hF080F010F0, 40'hF080F090F0, 40'hF010204040,
    40'hF090F090F0, 40'hF090F010F0, 40'hF090F09090, 40'hE090E090E0,
    40'hF0808080F0, 40'hE0909090E0, 40'hF080F080F0, 40'hF080F08080
  };

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rom_valid = 1'b0, rom_last = 1'b0;
  logic [7:0]  rom_data = 8'h00;
  logic        rom_ready;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [11:0] cpu_addr = 12'h000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_gnt, cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        dbg_req = 1'b0;
  logic [11:0] dbg_addr = 12'h000;
  logic        dbg_gnt, dbg_rvalid;
  logic [7:0]  dbg_rdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        system_ready, rom_overflow;
  logic [11:0] load_count;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.ROM_BASE(ROM_BASE), .FONT_BASE(FONT_BASE)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .rom_valid(rom_valid), .rom_data(rom_data), .rom_last(rom_last), .rom_ready(rom_ready),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .system_ready(system_ready), .rom_overflow(rom_overflow), .load_count(load_count)
  );

  // Synchronous single-port memory attached to the DUT
  logic [7:0] ram [4096];
  always @(posedge clk_in) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  function automatic logic [7:0] fontByte(input int i);
    logic [39:0] g;
    g = GLYPH[i / 5];
    return g[39 - 8 * (i % 5) -: 8];
  endfunction

  function automatic void checkOutput(input string name, input logic [31:0] actual,
                                      input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endfunction

  // Reference model: phase 0 font, 1 rom load, 2 run
  int         mPhase = 0, mFontIdx = 0, mLoad = 0;
  bit         mOvf = 0, mCpuLast = 0, mCpuPend = 0, mDbgPend = 0;
  logic [11:0] mCpuPendAddr = 12'h000, mDbgPendAddr = 12'h000;
  logic [7:0]  expMem [4096];

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = 8'h00;
      expMem[i] = 8'h00;
    end
  end

  // Compare process: evaluate the model with current inputs, check, then advance it
  always @(negedge clk_in) begin
    bit          eWe, eCpuG, eDbgG, addrValid;
    logic [11:0] eAddr;
    logic [7:0]  eWdata;
    if (!rst_in) begin
      mPhase = 0; mFontIdx = 0; mLoad = 0; mOvf = 0; mCpuLast = 0;
      mCpuPend = 0; mDbgPend = 0;
      checkOutput("rst_rom_ready", 32'(rom_ready), 0);
      checkOutput("rst_system_ready", 32'(system_ready), 0);
      checkOutput("rst_cpu_gnt", 32'(cpu_gnt), 0);
      checkOutput("rst_dbg_gnt", 32'(dbg_gnt), 0);
      checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
      checkOutput("rst_dbg_rvalid", 32'(dbg_rvalid), 0);
      checkOutput("rst_mem_we", 32'(mem_we), 0);
      checkOutput("rst_rom_overflow", 32'(rom_overflow), 0);
      checkOutput("rst_load_count", 32'(load_count), 0);
    end else begin
      eWe = 0; eCpuG = 0; eDbgG = 0; addrValid = 0; eAddr = 12'h000; eWdata = 8'h00;
      if (mPhase == 0) begin
        eWe = 1; eAddr = 12'(FONT_BASE + mFontIdx); eWdata = fontByte(mFontIdx);
      end else if (mPhase == 1) begin
        if (rom_valid && mLoad < CAP) begin
          eWe = 1; eAddr = 12'(ROM_BASE + mLoad); eWdata = rom_data;
        end
      end else begin
        if (cpu_req && dbg_req) begin
          eCpuG = !mCpuLast; eDbgG = mCpuLast;
        end else begin
          eCpuG = cpu_req; eDbgG = dbg_req;
        end
        eWe = eCpuG && cpu_we;
        eAddr = eCpuG ? cpu_addr : dbg_addr;
        eWdata = cpu_wdata;
        addrValid = eCpuG || eDbgG;
      end

      checkOutput("rom_ready", 32'(rom_ready), 32'(mPhase == 1));
      checkOutput("system_ready", 32'(system_ready), 32'(mPhase == 2));
      checkOutput("cpu_gnt", 32'(cpu_gnt), 32'(eCpuG));
      checkOutput("dbg_gnt", 32'(dbg_gnt), 32'(eDbgG));
      checkOutput("mem_we", 32'(mem_we), 32'(eWe));
      if (eWe) checkOutput("mem_wdata", 32'(mem_wdata), 32'(eWdata));
      if (eWe || addrValid) checkOutput("mem_addr", 32'(mem_addr), 32'(eAddr));
      checkOutput("cpu_rvalid", 32'(cpu_rvalid), 32'(mCpuPend));
      if (mCpuPend) checkOutput("cpu_rdata", 32'(cpu_rdata), 32'(expMem[mCpuPendAddr]));
      checkOutput("dbg_rvalid", 32'(dbg_rvalid), 32'(mDbgPend));
      if (mDbgPend) checkOutput("dbg_rdata", 32'(dbg_rdata), 32'(expMem[mDbgPendAddr]));
      checkOutput("rom_overflow", 32'(rom_overflow), 32'(mOvf));
      checkOutput("load_count", 32'(load_count), 32'(mLoad));

      mCpuPend = 0; mDbgPend = 0;
      if (mPhase == 0) begin
        expMem[eAddr] = eWdata;
        mFontIdx++;
        if (mFontIdx == 80) mPhase = 1;
      end else if (mPhase == 1) begin
        if (rom_valid) begin
          if (mLoad < CAP) begin
            expMem[12'(ROM_BASE + mLoad)] = rom_data;
            mLoad++;
          end else begin
            mOvf = 1;
          end
          if (rom_last) mPhase = 2;
        end
      end else begin
        if (eWe) expMem[cpu_addr] = cpu_wdata;
        if (eCpuG && !cpu_we) begin mCpuPend = 1; mCpuPendAddr = cpu_addr; end
        if (eDbgG) begin mDbgPend = 1; mDbgPendAddr = dbg_addr; end
        if (eCpuG) mCpuLast = 1;
        if (eDbgG) mCpuLast = 0;
      end
    end
  end

  // Drives one cycle of inputs, samples DUT outputs mid-cycle, returns just after the next edge
  bit         sCpuG, sDbgG, sCpuRv, sDbgRv, sRomRdy, sSysRdy, sWe;
  logic [7:0] sCpuRd, sDbgRd;
  task automatic applyStimulus(input bit rv, input logic [7:0] rd, input bit rl,
                               input bit cr, input bit cw, input logic [11:0] ca,
                               input logic [7:0] cd, input bit dr, input logic [11:0] da);
    rom_valid = rv; rom_data = rd; rom_last = rl;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_addr = da;
    @(negedge clk_in);
    sCpuG = cpu_gnt; sDbgG = dbg_gnt; sCpuRv = cpu_rvalid; sDbgRv = dbg_rvalid;
    sCpuRd = cpu_rdata; sDbgRd = dbg_rdata; sRomRdy = rom_ready; sSysRdy = system_ready;
    sWe = mem_we;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000);
  endtask

  task automatic waitReady(input int budget);
    int n;
    n = 0;
    while (!system_ready && n < budget) begin
      idle(1);
      n++;
    end
    checkOutput("wait_system_ready", 32'(system_ready), 1);
  endtask

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    checkOutput("lit_reset_we", 32'(mem_we), 0);
    rst_in = 1'b1;

    // Font load: 80 writes, rom_ready appears on cycle 81
    for (int i = 0; i < 82; i++) begin
      idle(1);
      if (i == 0)  checkOutput("lit_first_font_we", 32'(sWe), 1);
      if (i == 79) checkOutput("lit_cycle80_rom_ready", 32'(sRomRdy), 0);
      if (i == 80) begin
        checkOutput("lit_cycle81_rom_ready", 32'(sRomRdy), 1);
        checkOutput("lit_cycle81_we", 32'(sWe), 0);
        checkOutput("lit_cycle81_sys_ready", 32'(sSysRdy), 0);
      end
    end
    checkOutput("lit_font_000", 32'(ram[12'h000]), 32'hF0);
    checkOutput("lit_font_005", 32'(ram[12'h005]), 32'h20);
    checkOutput("lit_font_00A", 32'(ram[12'h00A]), 32'hF0);
    checkOutput("lit_font_04F", 32'(ram[12'h04F]), 32'h80);

    // Short ROM: AA, BB, CC
    applyStimulus(1, 8'hAA, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    applyStimulus(1, 8'hBB, 0, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    applyStimulus(1, 8'hCC, 1, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    waitReady(4);
    checkOutput("lit_load_count_3", 32'(load_count), 3);
    checkOutput("lit_rom_200", 32'(ram[12'h200]), 32'hAA);
    checkOutput("lit_rom_201", 32'(ram[12'h201]), 32'hBB);
    checkOutput("lit_rom_202", 32'(ram[12'h202]), 32'hCC);

    // Stray stream bytes in RUN are ignored
    applyStimulus(1, 8'h77, 1, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    checkOutput("lit_run_rom_we", 32'(sWe), 0);

    // Both requesting for 4 cycles: CPU, DBG, CPU, DBG
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 8'h00, 0, 1, 0, 12'h000, 8'h00, 1, 12'h005);
      checkOutput("lit_rr_cpu", 32'(sCpuG), 32'(i % 2 == 0));
      checkOutput("lit_rr_dbg", 32'(sDbgG), 32'(i % 2 == 1));
      if (i == 1) begin
        checkOutput("lit_rr_cpu_rv", 32'(sCpuRv), 1);
        checkOutput("lit_rr_cpu_rd", 32'(sCpuRd), 32'hF0);
      end
      if (i == 2) begin
        checkOutput("lit_rr_dbg_rv", 32'(sDbgRv), 1);
        checkOutput("lit_rr_dbg_rd", 32'(sDbgRd), 32'h20);
      end
    end
    idle(1);
    checkOutput("lit_rr_tail_dbg_rv", 32'(sDbgRv), 1);
    checkOutput("lit_rr_tail_cpu_rv", 32'(sCpuRv), 0);

    // Write 0x300=5A then read it back
    applyStimulus(0, 8'h00, 0, 1, 1, 12'h300, 8'h5A, 0, 12'h000);
    applyStimulus(0, 8'h00, 0, 1, 0, 12'h300, 8'h00, 0, 12'h000);
    checkOutput("lit_wr_no_rvalid", 32'(sCpuRv), 0);
    idle(1);
    checkOutput("lit_rd_300_rv", 32'(sCpuRv), 1);
    checkOutput("lit_rd_300_data", 32'(sCpuRd), 32'h5A);

    // Lone debug read and back-to-back CPU reads
    applyStimulus(0, 8'h00, 0, 0, 0, 12'h000, 8'h00, 1, 12'h202);
    checkOutput("lit_dbg_alone_gnt", 32'(sDbgG), 1);
    applyStimulus(0, 8'h00, 0, 1, 0, 12'h200, 8'h00, 0, 12'h000);
    applyStimulus(0, 8'h00, 0, 1, 0, 12'h201, 8'h00, 0, 12'h000);
    checkOutput("lit_b2b_cpu_rd0", 32'(sCpuRd), 32'hAA);
    idle(1);
    checkOutput("lit_b2b_cpu_rd1", 32'(sCpuRd), 32'hBB);

    // Reset with a CPU read in flight: the return must be discarded
    applyStimulus(0, 8'h00, 0, 1, 0, 12'h201, 8'h00, 0, 12'h000);
    rst_in = 1'b0;
    idle(2);
    checkOutput("lit_inflight_dropped", 32'(sCpuRv), 0);
    rst_in = 1'b1;

    // Reload, then reset after 10 ROM bytes
    idle(81);
    for (int i = 0; i < 10; i++) applyStimulus(1, 8'(8'h10 + i), 0, 0, 0, 12'h000, 8'h00, 0, 12'h000);
    checkOutput("lit_ten_loaded", 32'(load_count), 10);
    rst_in = 1'b0;
    #1;
    checkOutput("lit_midrom_rst_ready", 32'(rom_ready), 0);
    checkOutput("lit_midrom_rst_count", 32'(load_count), 0);
    checkOutput("lit_midrom_rst_we", 32'(mem_we), 0);
    idle(2);
    rst_in = 1'b1;
    idle(81);
    checkOutput("lit_restart_count", 32'(load_count), 0);
    checkOutput("lit_restart_rom_ready", 32'(sRomRdy), 1);
    checkOutput("lit_ten_209", 32'(ram[12'h209]), 32'h19);

    // Overflow: 3585 bytes, the last one beyond capacity
    for (int i = 0; i < 3585; i++)
      applyStimulus(1, 8'(i), (i == 3584), 0, 0, 12'h000, 8'h00, 0, 12'h000);
    waitReady(4);
    checkOutput("lit_ovf_flag", 32'(rom_overflow), 1);
    checkOutput("lit_ovf_count", 32'(load_count), 32'hE00);
    checkOutput("lit_ovf_fff", 32'(ram[12'hFFF]), 32'hFF);
    checkOutput("lit_ovf_no_wrap", 32'(ram[12'h000]), 32'hF0);
    checkOutput("lit_ovf_200", 32'(ram[12'h200]), 32'h00);
    idle(2);
    checkOutput("lit_ovf_hold", 32'(rom_overflow), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
